// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, issues a single
// aligned 64-bit memory access, and returns aligned/extended load data.
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_stall,
    input  logic [63:0] mem_data,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        pipe_stall
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg, uns_reg, err_reg;
    logic [1:0]    size_reg;
    logic [63:0]   addr_reg, wdata_reg, data_reg;
    logic [4:0]    rd_reg;

    logic          misaligned;
    logic          accept;
    logic          wait_done;
    logic          wait_timeout;
    logic [5:0]    shamt;
    logic [63:0]   size_mask;
    logic [7:0]    be_base;
    logic [63:0]   shifted;
    logic          sign_bit;
    logic [63:0]   load_data;

    assign accept = (state_reg == IDLE) && req_valid;
    assign wait_done = (state_reg == WAIT) && !mem_stall;
    assign wait_timeout = (state_reg == WAIT) && mem_stall && (cnt_reg == CW'(TIMEOUT - 1));

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Lane geometry derives from the latched request, so it stays stable through WAIT.
    assign shamt = {addr_reg[2:0], 3'b000};

    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        be_base   = 8'hFF;
        case (size_reg)
            2'b00:   begin size_mask = 64'h0000_0000_0000_00FF; be_base = 8'h01; end
            2'b01:   begin size_mask = 64'h0000_0000_0000_FFFF; be_base = 8'h03; end
            2'b10:   begin size_mask = 64'h0000_0000_FFFF_FFFF; be_base = 8'h0F; end
            default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; be_base = 8'hFF; end
        endcase
    end

    assign shifted = mem_data >> shamt;

    always_comb begin
        sign_bit = 1'b0;
        case (size_reg)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
    end

    assign load_data = (shifted & size_mask) | ((sign_bit && !uns_reg) ? ~size_mask : 64'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE:  if (req_valid) state_next = misaligned ? RESP : ISSUE;
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                if (wait_done || wait_timeout) state_next = RESP;
                else                           cnt_next   = cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= 64'd0;
            wdata_reg <= 64'd0;
            data_reg  <= 64'd0;
            rd_reg    <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                size_reg  <= req_size;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                rd_reg    <= req_rd;
                err_reg   <= misaligned;
                data_reg  <= 64'd0;
            end else if (wait_done) begin
                data_reg <= we_reg ? 64'd0 : load_data;
            end else if (wait_timeout) begin
                err_reg  <= 1'b1;
                data_reg <= 64'd0;
            end
        end
    end

    // All outputs decode from state so the asynchronous reset clears them immediately.
    assign req_ready  = (state_reg == IDLE);
    assign mem_valid  = (state_reg == ISSUE) || (state_reg == WAIT);
    assign mem_rw     = mem_valid && we_reg;
    assign mem_addr   = mem_valid ? {addr_reg[63:3], 3'b000} : 64'd0;
    assign mem_wdata  = (mem_valid && we_reg) ? ((wdata_reg & size_mask) << shamt) : 64'd0;
    assign mem_be     = (mem_valid && we_reg) ? (be_base << addr_reg[2:0]) : 8'h00;
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = resp_valid ? data_reg : 64'd0;
    assign resp_rd    = (resp_valid && !we_reg) ? rd_reg : 5'd0;
    assign resp_err   = resp_valid && err_reg;
    assign pipe_stall = (req_valid && !req_ready) || mem_valid;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of load/store vectors with a scoreboard of
// expected responses, plus hand sequences for reset and busy-time requests.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ready;
    logic        mem_valid, mem_rw;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_stall = 1'b0;
    logic [63:0] mem_data = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        pipe_stall;

    int total = 0;
    int bad = 0;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .req_ready(req_ready),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_stall(mem_stall), .mem_data(mem_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_err(resp_err), .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        int          n_stall;
        logic [63:0] mdata;
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_data;
        logic [4:0]  e_rd;
        logic        e_err;
        int          e_cyc;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [4:0] rd, input int n_stall, input logic [63:0] mdata,
                                input logic [63:0] e_addr, input logic [7:0] e_be,
                                input logic [63:0] e_wdata, input logic [63:0] e_data,
                                input logic [4:0] e_rd, input logic e_err, input int e_cyc);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.n_stall = n_stall; v.mdata = mdata;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data;
        v.e_rd = e_rd; v.e_err = e_err; v.e_cyc = e_cyc;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e, g;
        int c, k;
        bit got;
        @(negedge clk);
        chk("ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd; mem_data = v.mdata;
        e.data = v.e_data; e.rd = v.e_rd; e.err = v.e_err;
        e.lat = (v.e_cyc == 0) ? 1 : v.e_cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = 0; k = 0; got = 0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            if (mem_valid) begin
                k++;
                chk("mem_addr", mem_addr, v.e_addr);
                chk("mem_be", {56'd0, mem_be}, {56'd0, v.e_be});
                chk("mem_wdata", mem_wdata, v.e_wdata);
                chk("mem_rw", {63'd0, mem_rw}, {63'd0, v.we});
                chk("pipe_stall", {63'd0, pipe_stall}, 64'd1);
                mem_stall = (k <= v.n_stall + 1);
            end else begin
                mem_stall = 1'b0;
            end
            if (resp_valid) begin
                got = 1;
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'd0, 64'd1);
                end else begin
                    g = sb.pop_front();
                    chk("resp_data", resp_data, g.data);
                    chk("resp_rd", {59'd0, resp_rd}, {59'd0, g.rd});
                    chk("resp_err", {63'd0, resp_err}, {63'd0, g.err});
                    chk("latency", 64'(c), 64'(g.lat));
                    chk("mem_valid_in_resp", {63'd0, mem_valid}, 64'd0);
                end
            end
        end
        if (!got) chk("resp_timeout", 64'd0, 64'd1);
        chk("mem_cycles", 64'(k), 64'(v.e_cyc));
        mem_stall = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        chk("ready_after", {63'd0, req_ready}, 64'd1);
        $display("txn %0d we=%0d size=%0d addr=%h data=%h err=%0d lat=%0d", idx, v.we, v.size,
                 v.addr, resp_data, e.err, c);
    endtask

    initial begin
        // we sz uns addr wdata rd stall mdata | e_addr be e_wdata e_data e_rd err cyc
        vecs.push_back(mk(0, 2'd3, 0, 64'h1000, 0, 5, 4, 64'h1000,
                          64'h1000, 8'h00, 0, 64'h1000, 5, 0, 6));
        vecs.push_back(mk(0, 2'd0, 0, 64'h1007, 0, 7, 0, 64'h80AB_CDEF_0123_4567,
                          64'h1000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80, 7, 0, 2));
        vecs.push_back(mk(0, 2'd0, 1, 64'h1007, 0, 8, 0, 64'h80AB_CDEF_0123_4567,
                          64'h1000, 8'h00, 0, 64'h80, 8, 0, 2));
        vecs.push_back(mk(1, 2'd1, 0, 64'h2002, 64'hBEEF, 9, 1, 64'h1111,
                          64'h2000, 8'h0C, 64'h0000_0000_BEEF_0000, 0, 0, 0, 3));
        vecs.push_back(mk(0, 2'd2, 0, 64'h3002, 0, 3, 0, 64'h2222,
                          64'h0, 8'h00, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 2'd3, 0, 64'h4000, 0, 4, 100, 64'h3333,
                          64'h4000, 8'h00, 0, 0, 4, 1, 17));
        vecs.push_back(mk(0, 2'd1, 0, 64'h5006, 0, 10, 2, 64'h8001_0000_0000_0000,
                          64'h5000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001, 10, 0, 4));
        vecs.push_back(mk(0, 2'd2, 0, 64'h6004, 0, 11, 0, 64'h7FFF_FFFF_1234_5678,
                          64'h6000, 8'h00, 0, 64'h7FFF_FFFF, 11, 0, 2));
        vecs.push_back(mk(1, 2'd2, 0, 64'h7004, 64'hFFFF_FFFF_DEAD_BEEF, 12, 0, 0,
                          64'h7000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 2));
        vecs.push_back(mk(1, 2'd0, 0, 64'h8003, 64'h5A, 13, 3, 0,
                          64'h8000, 8'h08, 64'h5A00_0000, 0, 0, 0, 5));
        vecs.push_back(mk(1, 2'd3, 0, 64'h9000, 64'h0123_4567_89AB_CDEF, 14, 0, 0,
                          64'h9000, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 2));
        vecs.push_back(mk(1, 2'd3, 0, 64'hA004, 64'h77, 15, 0, 0,
                          64'h0, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 2'd2, 1, 64'hB004, 0, 16, 1, 64'h9000_0001_5555_5555,
                          64'hB000, 8'h00, 0, 64'h9000_0001, 16, 0, 3));
        vecs.push_back(mk(0, 2'd0, 0, 64'h0, 0, 17, 0, 64'hFFFF_FFFF_FFFF_FF7F,
                          64'h0, 8'h00, 0, 64'h7F, 17, 0, 2));

        // reset state, checked both while held and after release
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("idle_mem_be", {56'd0, mem_be}, 64'd0);
        chk("idle_pipe_stall", {63'd0, pipe_stall}, 64'd0);
        chk("idle_resp_data", resp_data, 64'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // req_valid held high throughout an access: stalls upstream, never re-accepted mid-access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h1000; req_rd = 5'd2; mem_data = 64'h55; mem_stall = 1'b0;
        @(negedge clk);
        chk("busy_ready_issue", {63'd0, req_ready}, 64'd0);
        chk("busy_stall_issue", {63'd0, pipe_stall}, 64'd1);
        @(negedge clk);
        chk("busy_stall_wait", {63'd0, pipe_stall}, 64'd1);
        @(negedge clk);
        chk("busy_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("busy_resp_data", resp_data, 64'h55);
        chk("busy_stall_resp", {63'd0, pipe_stall}, 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_resp_once", {63'd0, resp_valid}, 64'd0);
        chk("busy_idle_mem", {63'd0, mem_valid}, 64'd0);
        $display("txn busy-hold resp checked");

        // reset pulsed in WAIT: access abandoned, no response
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h1000; req_size = 2'd3; req_we = 1'b0;
        mem_stall = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_mem_valid", {63'd0, mem_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("async_ready", {63'd0, req_ready}, 64'd1);
        chk("async_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_stall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("post_rst_resp", {63'd0, resp_valid}, 64'd0);
            chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        end
        $display("txn reset-in-wait checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max WAIT cycles before the access is abandoned.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a load/store.
REQ-005 SHALL have port req_we  in  1  1=store, 0=load.
REQ-006 SHALL have port req_size  in  2  00=byte, 01=half, 10=word, 11=dword.
REQ-007 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have ports req_addr  in  64, req_wdata  in  64 (store data in low bits), req_rd  in  5 (load destination).
REQ-009 SHALL have port req_ready  out  1  request accepted on req_valid&req_ready.
REQ-010 SHALL have ports mem_valid  out  1, mem_rw  out  1 (1=write), mem_addr  out  64 (8-byte aligned), mem_wdata  out  64, mem_be  out  8.
REQ-011 SHALL have ports mem_stall  in  1 (responder busy), mem_data  in  64 (read word).
REQ-012 SHALL have ports resp_valid  out  1, resp_data  out  64, resp_rd  out  5, resp_err  out  1 (misaligned or timeout).
REQ-013 SHALL have port pipe_stall  out  1  freezes upstream pipeline.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 SHALL hold req_ready=1 only in IDLE; on acceptance, latch all req_* fields and enter ISSUE.
REQ-016 SHALL detect misalignment at acceptance: half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0; then go directly to RESP with resp_err=1, no memory access.
REQ-017 SHALL in ISSUE drive mem_valid=1 for exactly one cycle, ignore mem_stall, then enter WAIT.
REQ-018 SHALL in WAIT keep mem_valid=1 and mem_addr/mem_rw/mem_wdata/mem_be stable; on mem_stall=0 capture mem_data and enter RESP.
REQ-019 SHALL count WAIT cycles; when count reaches TIMEOUT with mem_stall still 1, drop mem_valid, enter RESP with resp_err=1, resp_data=0.
REQ-020 SHALL drive mem_addr={addr[63:3],3'b000}; mem_be lanes from addr[2:0] and size (byte 1 bit, half 2, word 4, dword 8'hFF); mem_wdata = store data shifted to lane addr[2:0]*8; mem_be=0 on loads.
REQ-021 SHALL in RESP assert resp_valid for exactly one cycle with resp_rd=latched rd, then return to IDLE.
REQ-022 SHALL form load resp_data by shifting captured word right by addr[2:0]*8, truncating to size, sign- or zero-extending to 64 bits.
REQ-023 SHALL on stores and errors set resp_data=0; resp_rd=0 on stores.
REQ-024 SHALL drive pipe_stall = (req_valid & ~req_ready) | (state is ISSUE or WAIT).
REQ-025 SHALL hold resp_valid=0 and mem_valid=0 in IDLE; minimum accept-to-resp_valid latency is 3 cycles (misaligned: 1).
REQ-026 SHALL ignore req_valid outside IDLE; no request queueing.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, timeout counter 0, and all outputs 0 except req_ready=1.
REQ-028 SHALL on reset mid-access (ISSUE/WAIT) abandon the access with no resp_valid; mem_valid drops asynchronously.

Verification
REQ-029 SHALL cover aligned dword load: addr=0x1000, responder stalls 4 cycles returning 0x1000 -> mem_addr=0x1000, mem_be=0, resp_valid once with resp_data=0x1000.
REQ-030 SHALL cover signed byte load: addr=0x1007, mem_data=0x80XX_XXXX_XXXX_XXXX -> resp_data=0xFFFF_FFFF_FFFF_FF80; with req_unsigned=1 -> 0x80.
REQ-031 SHALL cover half store: addr=0x2002, wdata=0xBEEF -> mem_rw=1, mem_addr=0x2000, mem_be=8'h0C, mem_wdata[31:16]=0xBEEF, resp_data=0.
REQ-032 SHALL cover misaligned word load at addr=0x3002 -> mem_valid never asserts; resp_valid and resp_err=1 the cycle after acceptance.
REQ-033 SHALL cover timeout: mem_stall held 1 -> resp_err=1 after TIMEOUT WAIT cycles, mem_valid low next cycle, FSM back in IDLE.
REQ-034 SHALL cover rst_n pulsed low during WAIT -> mem_valid=0 at once, no resp_valid, req_ready=1 after release.
